pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M, M/W).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg_if.sv | 49 ++++
 rtl/tnew_sat_dec.sv | 16 +
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [4:0]  ZERO_REG   = 5'd0;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam int          TNEW_W     = 2;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  link_sel;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [REG_ADDR_W-1:0] a2;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bundle: upstream slot, stall/flush control, registered slot and hazard outputs.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int TNEW_W   = 2,
  parameter int CNT_W    = 8
);
  logic                       en;
  logic                       flush;
  logic                       in_valid;
  logic [31:0]                in_instr;
  logic [31:0]                in_pc;
  logic [NUM_DATA*DATA_W-1:0] in_data;
  logic                       in_reg_write;
  logic                       in_mem_to_reg;
  logic                       in_link_sel;
  logic [REG_ADDR_W-1:0]      in_write_reg;
  logic [REG_ADDR_W-1:0]      in_a2;
  logic [TNEW_W-1:0]          in_tnew;

  logic                       out_valid;
  logic [31:0]                out_instr;
  logic [31:0]                out_pc;
  logic [NUM_DATA*DATA_W-1:0] out_data;
  logic                       out_reg_write;
  logic                       out_mem_to_reg;
  logic                       out_link_sel;
  logic [REG_ADDR_W-1:0]      out_write_reg;
  logic [REG_ADDR_W-1:0]      out_a2;
  logic [TNEW_W-1:0]          out_tnew;
  logic                       fwd_ready;
  logic [CNT_W-1:0]           hold_cycles;

  modport master (
    output en, flush, in_valid, in_instr, in_pc, in_data, in_reg_write, in_mem_to_reg,
           in_link_sel, in_write_reg, in_a2, in_tnew,
    input  out_valid, out_instr, out_pc, out_data, out_reg_write, out_mem_to_reg,
           out_link_sel, out_write_reg, out_a2, out_tnew, fwd_ready, hold_cycles
  );

  modport slave (
    input  en, flush, in_valid, in_instr, in_pc, in_data, in_reg_write, in_mem_to_reg,
           in_link_sel, in_write_reg, in_a2, in_tnew,
    output out_valid, out_instr, out_pc, out_data, out_reg_write, out_mem_to_reg,
           out_link_sel, out_write_reg, out_a2, out_tnew, fwd_ready, hold_cycles
  );
endinterface

// File: rtl/tnew_sat_dec.sv
// Saturating Tnew decrement applied as an instruction crosses one stage boundary.
module tnew_sat_dec #(
  parameter int TNEW_W   = 2,
  parameter int TNEW_DEC = 1
) (
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [TNEW_W-1:0] tnew_o
);
  logic [31:0] tnew_wide;
  logic [31:0] dec_wide;

  // Compare at 32 bits so a TNEW_DEC wider than the field still saturates to zero.
  assign tnew_wide = 32'(tnew_i);
  assign dec_wide  = 32'(TNEW_DEC);
  assign tnew_o    = (tnew_wide > dec_wide) ? TNEW_W'(tnew_wide - dec_wide) : '0;
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, Tnew countdown, forwarding flag and hold counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          NUM_DATA = 2,
  parameter int          TNEW_W   = 2,
  parameter int          TNEW_DEC = 1,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter bit          KEEP_PC  = 1'b1,
  parameter int          CNT_W    = 8
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  logic                       valid_q, valid_d;
  logic [31:0]                instr_q, instr_d;
  logic [31:0]                pc_q, pc_d;
  logic [NUM_DATA*DATA_W-1:0] data_q, data_d;
  ctrl_t                      ctrl_q, ctrl_d;
  logic [TNEW_W-1:0]          tnew_q, tnew_d;
  logic [CNT_W-1:0]           hold_q, hold_d;
  logic [TNEW_W-1:0]          tnew_dec;

  tnew_sat_dec #(
    .TNEW_W   (TNEW_W),
    .TNEW_DEC (TNEW_DEC)
  ) u_tnew_dec (
    .tnew_i (bus.in_tnew),
    .tnew_o (tnew_dec)
  );

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    tnew_d  = tnew_q;
    hold_d  = hold_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = KEEP_PC ? bus.in_pc : '0;
      data_d  = '0;
      ctrl_d  = BUBBLE_CTRL;
      tnew_d  = '0;
      hold_d  = '0;
    end else if (!bus.en) begin
      // Stalled: contents frozen, Tnew included, since the instruction has not advanced.
      hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_W'(1);
    end else begin
      valid_d           = bus.in_valid;
      instr_d           = bus.in_instr;
      pc_d              = bus.in_pc;
      data_d            = bus.in_data;
      ctrl_d.reg_write  = bus.in_reg_write;
      ctrl_d.mem_to_reg = bus.in_mem_to_reg;
      ctrl_d.link_sel   = bus.in_link_sel;
      ctrl_d.write_reg  = bus.in_write_reg;
      ctrl_d.a2         = bus.in_a2;
      tnew_d            = tnew_dec;
      hold_d            = '0;
      // An invalid slot must never look like a pending register write to the hazard unit.
      if (!bus.in_valid) begin
        ctrl_d.reg_write  = 1'b0;
        ctrl_d.mem_to_reg = 1'b0;
        ctrl_d.link_sel   = 1'b0;
        ctrl_d.write_reg  = ZERO_REG;
        tnew_d            = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      tnew_q  <= '0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      tnew_q  <= tnew_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_instr      = instr_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_data       = data_q;
  assign bus.out_reg_write  = ctrl_q.reg_write;
  assign bus.out_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.out_link_sel   = ctrl_q.link_sel;
  assign bus.out_write_reg  = ctrl_q.write_reg;
  assign bus.out_a2         = ctrl_q.a2;
  assign bus.out_tnew       = tnew_q;
  assign bus.hold_cycles    = hold_q;
  assign bus.fwd_ready      = valid_q & ctrl_q.reg_write &
                              (ctrl_q.write_reg != ZERO_REG) & (tnew_q == '0);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed stimulus for pipe_stage_reg, checked by a queue-based scoreboard.
module tb_pipe_stage_reg;

  typedef struct {
    logic        reset, en, flush, valid;
    logic [31:0] instr, pc;
    logic [63:0] data;
    logic        rw, mtr, ls;
    logic [4:0]  wr, a2;
    logic [1:0]  tnew;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc;
    logic [63:0] data;
    logic        rw, mtr, ls;
    logic [4:0]  wr, a2;
    logic [1:0]  tnew;
    logic        fwd;
    logic [7:0]  hold;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t model;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(2), .CNT_W(8)) bus ();

  pipe_stage_reg #(
    .DATA_W(32), .NUM_DATA(2), .TNEW_W(2), .TNEW_DEC(1),
    .RESET_PC(32'h0000_3000), .KEEP_PC(1'b1), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: reset, then flush, then stall, then load.
  function automatic exp_t model_next(exp_t cur, stim_t s);
    exp_t n = cur;
    if (s.reset) begin
      n = '{valid: 1'b0, instr: 0, pc: 32'h3000, data: 0, rw: 0, mtr: 0, ls: 0,
            wr: 0, a2: 0, tnew: 0, fwd: 0, hold: 0};
    end else if (s.flush) begin
      n = '{valid: 1'b0, instr: 0, pc: s.pc, data: 0, rw: 0, mtr: 0, ls: 0,
            wr: 0, a2: 0, tnew: 0, fwd: 0, hold: 0};
    end else if (!s.en) begin
      n.hold = (int'(cur.hold) + 1 > 255) ? 8'd255 : cur.hold + 8'd1;
    end else begin
      n.valid = s.valid;
      n.instr = s.instr;
      n.pc    = s.pc;
      n.data  = s.data;
      n.a2    = s.a2;
      n.hold  = 0;
      if (s.valid) begin
        n.rw   = s.rw;
        n.mtr  = s.mtr;
        n.ls   = s.ls;
        n.wr   = s.wr;
        n.tnew = (int'(s.tnew) > 1) ? 2'(int'(s.tnew) - 1) : 2'd0;
      end else begin
        n.rw = 0; n.mtr = 0; n.ls = 0; n.wr = 0; n.tnew = 0;
      end
    end
    n.fwd = n.valid && n.rw && (n.wr != 0) && (n.tnew == 0);
    return n;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset = 0; s.en = 1; s.flush = 0;
    s.valid = 1'($urandom);
    s.instr = $urandom;
    s.pc    = $urandom & 32'hFFFF_FFFC;
    s.data  = {$urandom, $urandom};
    s.rw    = 1'($urandom);
    s.mtr   = 1'($urandom);
    s.ls    = 1'($urandom);
    s.wr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    s.a2    = 5'($urandom);
    s.tnew  = 2'($urandom_range(0, 3));
    return s;
  endfunction

  // Apply one cycle of stimulus; returns 2 time units after the sampling edge.
  task automatic drive(input stim_t s);
    reset             = s.reset;
    bus.en            = s.en;
    bus.flush         = s.flush;
    bus.in_valid      = s.valid;
    bus.in_instr      = s.instr;
    bus.in_pc         = s.pc;
    bus.in_data       = s.data;
    bus.in_reg_write  = s.rw;
    bus.in_mem_to_reg = s.mtr;
    bus.in_link_sel   = s.ls;
    bus.in_write_reg  = s.wr;
    bus.in_a2         = s.a2;
    bus.in_tnew       = s.tnew;
    model = model_next(model, s);
    sb_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  // Monitor: the register presents a slot every cycle, so one expectation is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_valid",      64'(bus.out_valid),      64'(e.valid));
        chk("out_instr",      64'(bus.out_instr),      64'(e.instr));
        chk("out_pc",         64'(bus.out_pc),         64'(e.pc));
        chk("out_data",       bus.out_data,            e.data);
        chk("out_reg_write",  64'(bus.out_reg_write),  64'(e.rw));
        chk("out_mem_to_reg", 64'(bus.out_mem_to_reg), 64'(e.mtr));
        chk("out_link_sel",   64'(bus.out_link_sel),   64'(e.ls));
        chk("out_write_reg",  64'(bus.out_write_reg),  64'(e.wr));
        chk("out_a2",         64'(bus.out_a2),         64'(e.a2));
        chk("out_tnew",       64'(bus.out_tnew),       64'(e.tnew));
        chk("fwd_ready",      64'(bus.fwd_ready),      64'(e.fwd));
        chk("hold_cycles",    64'(bus.hold_cycles),    64'(e.hold));
      end
    end
  end

  initial begin
    stim_t s;
    stim_t base;
    model = '{valid: 0, instr: 0, pc: 0, data: 0, rw: 0, mtr: 0, ls: 0,
              wr: 0, a2: 0, tnew: 0, fwd: 0, hold: 0};
    reset = 1'b1;
    bus.en = 0; bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
    bus.in_data = 0; bus.in_reg_write = 0; bus.in_mem_to_reg = 0; bus.in_link_sel = 0;
    bus.in_write_reg = 0; bus.in_a2 = 0; bus.in_tnew = 0;
    @(posedge clk);
    #2;

    // Reset state
    s = rand_stim(); s.reset = 1; s.flush = 1'($urandom);
    drive(s);
    chk("rst_pc",    64'(bus.out_pc),      64'h3000);
    chk("rst_valid", 64'(bus.out_valid),   64'd0);
    chk("rst_tnew",  64'(bus.out_tnew),    64'd0);
    chk("rst_fwd",   64'(bus.fwd_ready),   64'd0);
    chk("rst_hold",  64'(bus.hold_cycles), 64'd0);

    // Tnew countdown to forwarding readiness
    base = rand_stim(); base.valid = 1; base.rw = 1; base.wr = 5'd8; base.tnew = 2'd2;
    drive(base);
    chk("tn2_tnew", 64'(bus.out_tnew),  64'd1);
    chk("tn2_fwd",  64'(bus.fwd_ready), 64'd0);
    base.tnew = 2'd1;
    drive(base);
    chk("tn1_tnew", 64'(bus.out_tnew),  64'd0);
    chk("tn1_fwd",  64'(bus.fwd_ready), 64'd1);

    // No underflow; $0 never forwards
    base.tnew = 2'd0;
    drive(base);
    chk("tn0_tnew", 64'(bus.out_tnew), 64'd0);
    base.wr = 5'd0;
    drive(base);
    chk("zero_fwd", 64'(bus.fwd_ready), 64'd0);

    // Long stall: contents frozen, counter saturates, clears on load
    base = rand_stim(); base.valid = 1; base.rw = 1; base.wr = 5'd9; base.tnew = 2'd3;
    drive(base);
    for (int i = 0; i < 300; i++) begin
      s = rand_stim(); s.en = 0;
      drive(s);
    end
    chk("sat_hold", 64'(bus.hold_cycles), 64'd255);
    chk("sat_tnew", 64'(bus.out_tnew),    64'd2);
    chk("sat_wr",   64'(bus.out_write_reg), 64'd9);
    s = rand_stim();
    drive(s);
    chk("unhold", 64'(bus.hold_cycles), 64'd0);

    // Flush during stall keeps incoming PC
    s = rand_stim(); s.en = 0; drive(s);
    s = rand_stim(); s.en = 0; s.flush = 1; s.valid = 1; s.rw = 1; s.pc = 32'h3010;
    drive(s);
    chk("fl_valid", 64'(bus.out_valid),     64'd0);
    chk("fl_rw",    64'(bus.out_reg_write), 64'd0);
    chk("fl_pc",    64'(bus.out_pc),        64'h3010);
    chk("fl_hold",  64'(bus.hold_cycles),   64'd0);

    // Invalid slot loads as bubble but keeps data
    s = rand_stim(); s.valid = 0; s.rw = 1; s.tnew = 2'd2; s.wr = 5'd12;
    drive(s);
    chk("iv_rw",   64'(bus.out_reg_write), 64'd0);
    chk("iv_tnew", 64'(bus.out_tnew),      64'd0);
    chk("iv_data", bus.out_data,           s.data);

    // Reset mid-stall wins, then inputs take effect next cycle
    for (int i = 0; i < 4; i++) begin s = rand_stim(); s.en = 0; drive(s); end
    s = rand_stim(); s.en = 0; s.reset = 1; drive(s);
    s = rand_stim(); s.en = 0; drive(s);
    chk("rs_hold", 64'(bus.hold_cycles), 64'd1);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      s.en    = ($urandom_range(0, 3) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.reset = ($urandom_range(0, 49) == 0);
      drive(s);
    end

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
